// File: rtl/ls_multiple_sequencer_if.sv
// Decode-side bundle between the decode stage and the load/store-multiple
// sequencer: instruction/stall inputs plus the per-word control outputs.
interface ls_multiple_sequencer_if #(
   parameter int GPR_IDX_W = 5
);
   logic [31:0]          inst;
   logic                 inst_valid;
   logic                 hold;
   logic                 flush;
   logic                 if_hold;
   logic                 if_gpr_c_over;
   logic [GPR_IDX_W-1:0] if_gpr_c;
   logic                 read_gpr_a;
   logic                 read_gpr_c;
   logic                 ls_en;
   logic                 ls_we;
   logic                 ls_multiple;
   logic                 ls_first_cycle;
   logic                 ls_multiple_inc;
   logic                 write_gpr_from_mem;
   logic [GPR_IDX_W-1:0] gpr_from_mem;
   logic                 illegal;

   modport master (
      output inst, inst_valid, hold, flush,
      input  if_hold, if_gpr_c_over, if_gpr_c, read_gpr_a, read_gpr_c,
             ls_en, ls_we, ls_multiple, ls_first_cycle, ls_multiple_inc,
             write_gpr_from_mem, gpr_from_mem, illegal
   );

   modport slave (
      input  inst, inst_valid, hold, flush,
      output if_hold, if_gpr_c_over, if_gpr_c, read_gpr_a, read_gpr_c,
             ls_en, ls_we, ls_multiple, ls_first_cycle, ls_multiple_inc,
             write_gpr_from_mem, gpr_from_mem, illegal
   );
endinterface

// File: rtl/ls_multiple_sequencer.sv
// Expands lmw/stmw into one control word per GPR (RT..31), one per cycle,
// stalling fetch until the last word. Outputs feed an OR reduction, so every
// output is zero whenever no word is being emitted.
module ls_multiple_sequencer #(
   parameter logic [5:0] OPC_LMW   = 6'd46,
   parameter logic [5:0] OPC_STMW  = 6'd47,
   parameter int         GPR_IDX_W = 5
) (
   input logic                clk,
   input logic                reset,
   ls_multiple_sequencer_if.slave bus
);

   localparam logic [GPR_IDX_W-1:0] LAST_GPR = {GPR_IDX_W{1'b1}};

   typedef enum logic {S_IDLE, S_ITER} state_t;

   state_t               state, state_nxt;
   logic [GPR_IDX_W-1:0] cur, cur_nxt;
   logic                 is_store, is_store_nxt;

   logic [5:0]           opcode;
   logic [GPR_IDX_W-1:0] rt, ra;
   logic                 is_lmw, is_stmw, bad, go;

   assign opcode  = bus.inst[31:26];
   assign rt      = bus.inst[25:21];
   assign ra      = bus.inst[20:16];
   assign is_lmw  = (opcode == OPC_LMW);
   assign is_stmw = (opcode == OPC_STMW);
   // lmw with RA inside the destination range would clobber its own base
   assign bad     = is_lmw && (ra >= rt);
   assign go      = bus.inst_valid && !bus.hold && !bus.flush;

   // state, current register and direction register
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cur      <= '0;
         is_store <= 1'b0;
      end else begin
         state    <= state_nxt;
         cur      <= cur_nxt;
         is_store <= is_store_nxt;
      end
   end

   // next state and per-cycle control word
   always_comb begin
      state_nxt              = state;
      cur_nxt                = cur;
      is_store_nxt           = is_store;
      bus.if_hold            = 1'b0;
      bus.if_gpr_c_over      = 1'b0;
      bus.if_gpr_c           = '0;
      bus.read_gpr_a         = 1'b0;
      bus.read_gpr_c         = 1'b0;
      bus.ls_en              = 1'b0;
      bus.ls_we              = 1'b0;
      bus.ls_multiple        = 1'b0;
      bus.ls_first_cycle     = 1'b0;
      bus.ls_multiple_inc    = 1'b0;
      bus.write_gpr_from_mem = 1'b0;
      bus.gpr_from_mem       = '0;
      bus.illegal            = 1'b0;

      case (state)
         S_IDLE: begin
            // while iterating, the decode slot still holds the sequence's own
            // instruction, so decoding (and illegal) is only done from IDLE
            if (go && is_lmw && bad) begin
               bus.illegal = 1'b1;
            end else if (go && (is_lmw || is_stmw)) begin
               bus.ls_en          = 1'b1;
               bus.ls_multiple    = 1'b1;
               bus.ls_first_cycle = 1'b1;
               bus.read_gpr_a     = 1'b1;
               bus.ls_we          = is_stmw;
               bus.if_hold        = (rt != LAST_GPR);
               if (is_stmw) begin
                  bus.read_gpr_c    = 1'b1;
                  bus.if_gpr_c_over = 1'b1;
                  bus.if_gpr_c      = rt;
               end else begin
                  bus.write_gpr_from_mem = 1'b1;
                  bus.gpr_from_mem       = rt;
               end
               // RT==31 is a single-word sequence: nothing left to iterate
               if (rt != LAST_GPR) begin
                  state_nxt    = S_ITER;
                  cur_nxt      = rt + 1'b1;
                  is_store_nxt = is_stmw;
               end
            end
         end
         S_ITER: begin
            if (bus.flush) begin
               state_nxt = S_IDLE;
            end else if (bus.hold) begin
               // reducer ignores held words; keep fetch stalled only
               bus.if_hold = 1'b1;
            end else begin
               bus.ls_en           = 1'b1;
               bus.ls_multiple     = 1'b1;
               bus.ls_multiple_inc = 1'b1;
               bus.ls_we           = is_store;
               // last word releases fetch so the next instruction decodes next
               bus.if_hold         = (cur != LAST_GPR);
               if (is_store) begin
                  bus.read_gpr_c    = 1'b1;
                  bus.if_gpr_c_over = 1'b1;
                  bus.if_gpr_c      = cur;
               end else begin
                  bus.write_gpr_from_mem = 1'b1;
                  bus.gpr_from_mem       = cur;
               end
               if (cur == LAST_GPR) state_nxt = S_IDLE;
               else                 cur_nxt   = cur + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
